// File: rtl/fixed_point_squarer.sv
// ---------------------------------------------------------------------------
// fixed_point_squarer
//   Sequential shift-and-add squarer for an unsigned INT_W.FRAC_W root code.
//   Produces the exact (2*INT_W).(2*FRAC_W) square and the square rounded to
//   the nearest integer (half rounds up, saturated to 2*INT_W bits), so a
//   root code can be mapped back to the integer it was derived from.
//   One operation is in flight at a time, with a valid/ready handshake on
//   both the input side and the output side.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x is valid
//   in_ready   block accepts x (only while idle)
//   x          root code, unsigned INT_W.FRAC_W
//   out_valid  sq and n_round are valid
//   out_ready  consumer takes the result
//   sq         x*x, unsigned (2*INT_W).(2*FRAC_W), exact
//   n_round    sq rounded to nearest integer, saturated
//   busy       high while calculating or holding a result
// ---------------------------------------------------------------------------
module fixed_point_squarer #(
  parameter int INT_W  = 2,
  parameter int FRAC_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W+FRAC_W-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*(INT_W+FRAC_W)-1:0] sq,
  output logic [2*INT_W-1:0]     n_round,
  output logic                   busy
);

  localparam int W     = INT_W + FRAC_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [2*W-1:0]     acc;
  logic [2*W-1:0]     mcand;
  logic [W-1:0]       mplr;
  logic [CNT_W-1:0]   cnt;

  logic [2*W-1:0]     acc_next;
  logic [2*INT_W:0]   rnd_sum;
  logic [2*INT_W-1:0] n_next;

  // Partial-product step for the current multiplier bit, and the rounded
  // integer derived from it. On the final step acc_next already holds the
  // complete square, so the result registers load it directly.
  always_comb begin
    acc_next = acc;
    if (mplr[0]) begin
      acc_next = acc + mcand;
    end
    // Integer part plus the half bit; the extra MSB catches the carry that
    // forces saturation (e.g. 15.5 and above rounds to 16, which cannot fit).
    rnd_sum = {1'b0, acc_next[2*W-1:2*FRAC_W]}
            + {{(2*INT_W){1'b0}}, acc_next[2*FRAC_W-1]};
    n_next  = rnd_sum[2*INT_W] ? {(2*INT_W){1'b1}} : rnd_sum[2*INT_W-1:0];
  end

  // Control and datapath. The handshake outputs are registered alongside
  // the state so they change exactly on the state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
      sq        <= '0;
      n_round   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{W{1'b0}}, x};
            mplr     <= x;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            sq        <= acc_next;
            n_round   <= n_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
